// File: rtl/ov7670_pkg.sv
// Shared types, default timing and helper functions for the OV7670-style stream generator.
package ov7670_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVback,
        StActive,
        StVfront
    } state_e;

    localparam int unsigned DEF_H_ACTIVE    = 640;
    localparam int unsigned DEF_H_BLANK     = 144;
    localparam int unsigned DEF_V_ACTIVE    = 480;
    localparam int unsigned DEF_VSYNC_LINES = 3;
    localparam int unsigned DEF_V_BACK      = 17;
    localparam int unsigned DEF_V_FRONT     = 10;
    localparam int unsigned DEF_ADDR_W      = 19;
    localparam logic [7:0]  DEF_PAD_BYTE    = 8'h00;

    // Each pixel period (active or blank) is two byte cycles.
    function automatic int unsigned line_len(input int unsigned h_active,
                                             input int unsigned h_blank);
        return 2 * (h_active + h_blank);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ov7670_stream_gen_if.sv
// Frame-buffer read port plus OV7670 camera output bus, as seen by the generator.
interface ov7670_stream_gen_if #(
    parameter int unsigned ADDR_W = 19
);
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_re;
    logic [7:0]        fb_rdata;
    logic              vsync;
    logic              href;
    logic [7:0]        dout;
    logic              frame_done;

    modport master (
        output fb_addr,
        output fb_re,
        input  fb_rdata,
        output vsync,
        output href,
        output dout,
        output frame_done
    );

    modport slave (
        input  fb_addr,
        input  fb_re,
        output fb_rdata,
        input  vsync,
        input  href,
        input  dout,
        input  frame_done
    );
endinterface

// File: rtl/ov7670_line_timer.sv
// Horizontal byte counter: wraps every line, flags the last cycle and the pre-href window.
module ov7670_line_timer #(
    parameter int unsigned LINE  = 1568,
    parameter int unsigned H_WIN = 1280,
    parameter int unsigned HW    = 11
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          i_run,
    output logic [HW-1:0] o_h_cnt,
    output logic          o_line_end,
    output logic          o_href_pre
);

    localparam logic [HW-1:0] H_LAST  = HW'(LINE - 1);
    localparam logic [HW-1:0] H_WIN_W = HW'(H_WIN);

    logic [HW-1:0] r_h_cnt;
    logic [HW-1:0] w_h_wrap;
    logic [HW-1:0] w_h_nxt;

    always_comb begin
        o_line_end = (r_h_cnt == H_LAST);
        w_h_wrap   = o_line_end ? '0 : r_h_cnt + 1'b1;
        // True when the following cycle lies inside the href window.
        o_href_pre = (w_h_wrap < H_WIN_W);
        w_h_nxt    = i_run ? w_h_wrap : '0;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_nxt;
        end
    end

    assign o_h_cnt = r_h_cnt;

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670 parallel-output emulator: streams a frame buffer as {pad, pixel} byte pairs with
// vsync/href framing; all outputs registered one cycle behind the timing counters.
module ov7670_stream_gen
    import ov7670_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_BLANK     = DEF_H_BLANK,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int unsigned V_BACK      = DEF_V_BACK,
    parameter int unsigned V_FRONT     = DEF_V_FRONT,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter logic [7:0]  PAD_BYTE    = DEF_PAD_BYTE
) (
    input  logic                pclk,
    input  logic                rst_n,
    input  logic                i_en,
    ov7670_stream_gen_if.master io_cam
);

    localparam int unsigned LINE  = line_len(H_ACTIVE, H_BLANK);
    localparam int unsigned H_WIN = 2 * H_ACTIVE;
    localparam int unsigned HW    = cnt_w(LINE);
    localparam int unsigned V_MAX = max_u(max_u(VSYNC_LINES, V_BACK), max_u(V_ACTIVE, V_FRONT));
    localparam int unsigned VW    = cnt_w(V_MAX);

    localparam logic [HW-1:0] H_WIN_W = HW'(H_WIN);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [VW-1:0]     r_v_cnt;
    logic [VW-1:0]     w_v_nxt;
    logic [VW-1:0]     w_v_last;
    logic              w_frame_end;
    logic              w_frame_start;
    logic              w_rd_issue;
    logic              w_href_now;

    logic [HW-1:0]     w_h_cnt;
    logic              w_line_end;
    logic              w_href_pre;

    logic [ADDR_W-1:0] r_addr_nxt;
    logic [ADDR_W-1:0] r_fb_addr;
    logic              r_fb_re;
    logic              r_vsync;
    logic              r_href;
    logic [7:0]        r_dout;
    logic              r_frame_done;

    ov7670_line_timer #(
        .LINE  (LINE),
        .H_WIN (H_WIN),
        .HW    (HW)
    ) u_line_timer (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .i_run      (r_state != StIdle),
        .o_h_cnt    (w_h_cnt),
        .o_line_end (w_line_end),
        .o_href_pre (w_href_pre)
    );

    always_comb begin
        w_v_last = '0;
        unique case (r_state)
            StVsync:  w_v_last = VW'(VSYNC_LINES - 1);
            StVback:  w_v_last = VW'(V_BACK - 1);
            StActive: w_v_last = VW'(V_ACTIVE - 1);
            StVfront: w_v_last = VW'(V_FRONT - 1);
            default:  w_v_last = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_v_nxt     = r_v_cnt;
        w_frame_end = 1'b0;
        if (r_state == StIdle) begin
            if (i_en) begin
                w_state_nxt = StVsync;
            end
        end else if (w_line_end) begin
            if (r_v_cnt == w_v_last) begin
                w_v_nxt = '0;
                unique case (r_state)
                    StVsync:  w_state_nxt = StVback;
                    StVback:  w_state_nxt = StActive;
                    StActive: w_state_nxt = StVfront;
                    StVfront: begin
                        w_frame_end = 1'b1;
                        w_state_nxt = i_en ? StVsync : StIdle;
                    end
                    default:  w_state_nxt = StIdle;
                endcase
            end else begin
                w_v_nxt = r_v_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_v_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_v_cnt <= w_v_nxt;
        end
    end

    // The read is issued one output cycle before the pad byte, so it keys off the
    // odd counter value preceding it and the state that the next cycle will be in.
    assign w_rd_issue    = (w_state_nxt == StActive) && w_href_pre && w_h_cnt[0];
    assign w_frame_start = (w_state_nxt == StVsync) && (r_state != StVsync);
    assign w_href_now    = (r_state == StActive) && (w_h_cnt < H_WIN_W);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_nxt   <= '0;
            r_fb_addr    <= '0;
            r_fb_re      <= 1'b0;
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_dout       <= 8'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_fb_re      <= w_rd_issue;
            r_vsync      <= (r_state == StVsync);
            r_href       <= w_href_now;
            r_frame_done <= w_frame_end;
            if (!w_href_now) begin
                r_dout <= 8'h00;
            end else if (w_h_cnt[0]) begin
                r_dout <= io_cam.fb_rdata;
            end else begin
                r_dout <= PAD_BYTE;
            end
            if (w_frame_start) begin
                r_fb_addr  <= '0;
                r_addr_nxt <= '0;
            end else if (w_rd_issue) begin
                r_fb_addr  <= r_addr_nxt;
                r_addr_nxt <= r_addr_nxt + 1'b1;
            end
        end
    end

    assign io_cam.fb_addr    = r_fb_addr;
    assign io_cam.fb_re      = r_fb_re;
    assign io_cam.vsync      = r_vsync;
    assign io_cam.href       = r_href;
    assign io_cam.dout       = r_dout;
    assign io_cam.frame_done = r_frame_done;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Scoreboard bench for ov7670_stream_gen with a small frame geometry and a synchronous RAM model.
module tb_ov7670_stream_gen;

    localparam int unsigned H_ACT   = 4;
    localparam int unsigned H_BLK   = 2;
    localparam int unsigned V_ACT   = 3;
    localparam int unsigned V_SYNC  = 1;
    localparam int unsigned V_BK    = 1;
    localparam int unsigned V_FR    = 1;
    localparam int unsigned AW      = 19;
    localparam logic [7:0]  PAD     = 8'hAA;
    localparam int          NPIX    = H_ACT * V_ACT;
    localparam int          LINE_C  = 2 * (H_ACT + H_BLK);
    localparam int          FRAME_C = LINE_C * (V_SYNC + V_BK + V_ACT + V_FR);
    localparam int          VS_C    = LINE_C * V_SYNC;
    localparam int          HREF_C  = LINE_C * (V_SYNC + V_BK);

    logic pclk;
    logic rst_n;
    logic en;

    ov7670_stream_gen_if #(.ADDR_W(AW)) cam ();

    ov7670_stream_gen #(
        .H_ACTIVE    (H_ACT),
        .H_BLANK     (H_BLK),
        .V_ACTIVE    (V_ACT),
        .VSYNC_LINES (V_SYNC),
        .V_BACK      (V_BK),
        .V_FRONT     (V_FR),
        .ADDR_W      (AW),
        .PAD_BYTE    (PAD)
    ) dut (
        .pclk   (pclk),
        .rst_n  (rst_n),
        .i_en   (en),
        .io_cam (cam)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic [7:0] mem [NPIX];

    always @(posedge pclk) begin
        if (cam.fb_re) cam.fb_rdata <= mem[int'(cam.fb_addr) % NPIX];
    end

    int n_cmp = 0;
    int n_bad = 0;
    int q_addr [$];
    int q_byte [$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    // Expected traffic for one frame: every address in raster order, each pixel as {PAD, pixel}.
    task automatic push_frame();
        for (int i = 0; i < NPIX; i++) begin
            q_addr.push_back(i);
            q_byte.push_back(int'(PAD));
            q_byte.push_back(int'(mem[i]));
        end
    endtask

    // Monitor state
    int  tcyc = 0;
    int  fstart = 0;
    int  last_done = -10;
    int  re_cnt = 0;
    int  n_done = 0;
    bit  in_frame = 0;
    bit  href_seen = 0;
    bit  prev_vs = 0;
    bit  prev_href = 0;
    bit  p0_v = 0;
    bit  p1_v = 0;
    int  p0_a = 0;
    int  p1_a = 0;

    always @(negedge pclk) begin
        tcyc++;
        if (!rst_n) begin
            p0_v = 0; p1_v = 0; prev_vs = 0; prev_href = 0; in_frame = 0;
        end else begin
            if (p1_v) begin
                chk("rd_lat_href", int'(cam.href), 1);
                chk("rd_lat_dout", int'(cam.dout), int'(mem[p1_a % NPIX]));
            end
            p1_v = p0_v; p1_a = p0_a;
            p0_v = cam.fb_re; p0_a = int'(cam.fb_addr);

            if (cam.fb_re) begin
                re_cnt++;
                if (q_addr.size() == 0) fail("fb_addr_unexpected_read");
                else chk("fb_addr", int'(cam.fb_addr), q_addr.pop_front());
            end
            if (cam.href) begin
                if (q_byte.size() == 0) fail("dout_unexpected_byte");
                else chk("dout_byte", int'(cam.dout), q_byte.pop_front());
            end else if (cam.dout !== 8'h00) begin
                chk("dout_zero_no_href", int'(cam.dout), 0);
            end
            if (cam.vsync && cam.href) fail("vsync_and_href_both_high");

            if (cam.vsync && !prev_vs) begin
                if (last_done == tcyc - 1) chk("frame_period", tcyc - fstart, FRAME_C);
                fstart = tcyc; re_cnt = 0; href_seen = 0; in_frame = 1;
            end
            if (!cam.vsync && prev_vs && in_frame) chk("vsync_width", tcyc - fstart, VS_C);
            if (cam.href && !prev_href && !href_seen && in_frame) begin
                chk("first_href_offset", tcyc - fstart, HREF_C);
                href_seen = 1;
            end
            if (cam.frame_done) begin
                if (in_frame) chk("frame_done_offset", tcyc - fstart, FRAME_C - 1);
                else fail("frame_done_outside_frame");
                chk("fb_re_per_frame", re_cnt, NPIX);
                n_done++;
                last_done = tcyc;
            end
            prev_vs = cam.vsync;
            prev_href = cam.href;
        end
    end

    task automatic wait_vs_rise(input int max_cyc, input string name);
        bit prev;
        bit hit;
        prev = cam.vsync;
        hit = 0;
        for (int i = 0; i < max_cyc && !hit; i++) begin
            @(negedge pclk);
            if (cam.vsync && !prev) hit = 1;
            prev = cam.vsync;
        end
        if (!hit) fail(name);
    endtask

    task automatic wait_done(input int target, input int max_cyc, input string name);
        for (int i = 0; i < max_cyc && n_done < target; i++) @(negedge pclk);
        if (n_done < target) fail(name);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_vsync"}, int'(cam.vsync), 0);
        chk({name, "_href"}, int'(cam.href), 0);
        chk({name, "_fb_re"}, int'(cam.fb_re), 0);
        chk({name, "_dout"}, int'(cam.dout), 0);
        chk({name, "_frame_done"}, int'(cam.frame_done), 0);
        chk({name, "_fb_addr"}, int'(cam.fb_addr), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        for (int i = 0; i < NPIX; i++) mem[i] = 8'(i + 'h10);
        repeat (3) @(negedge pclk);
        chk_all_zero("reset");

        // Single frame: en drops right after the frame has started.
        push_frame();
        #1;
        rst_n = 1'b1;
        en = 1'b1;
        wait_vs_rise(50, "timeout_first_vsync");
        #1 en = 1'b0;
        wait_done(1, 2 * FRAME_C, "timeout_frame1_done");
        repeat (6) begin
            @(negedge pclk);
            chk("idle_outputs", int'({cam.vsync, cam.href, cam.fb_re, cam.dout, cam.frame_done}), 0);
        end

        // Two back-to-back frames of a random image.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom_range(0, 255));
        push_frame();
        push_frame();
        #1 en = 1'b1;
        wait_vs_rise(50, "timeout_vsync_b1");
        wait_vs_rise(2 * FRAME_C, "timeout_vsync_b2");
        #1 en = 1'b0;
        wait_done(3, 2 * FRAME_C, "timeout_frame3_done");
        repeat (4) @(negedge pclk);

        // Reset in the middle of active line 1, pixel 2.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom_range(0, 255));
        push_frame();
        #1 en = 1'b1;
        wait_vs_rise(50, "timeout_vsync_c");
        repeat (HREF_C + LINE_C + 4) @(negedge pclk);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        q_addr.delete();
        q_byte.delete();
        repeat (2) @(negedge pclk);
        push_frame();
        #1 rst_n = 1'b1;
        wait_vs_rise(50, "timeout_vsync_after_reset");
        #1 en = 1'b0;
        wait_done(4, 2 * FRAME_C, "timeout_frame_after_reset");
        repeat (4) @(negedge pclk);

        chk("addr_queue_drained", q_addr.size(), 0);
        chk("byte_queue_drained", q_byte.size(), 0);
        chk("frames_completed", n_done, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
